rpn_stack_evaluator: RTL and testbench
======================================

RPN_STACK_EVALUATOR -- requirements
Module: rpn_stack_evaluator

Interface
REQ-001 Parameter DEPTH, default 8, stack entries (power of two, 2..16).
REQ-002 Parameter WIDTH, default 16, operand/result width.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 num_ready  input  1  one-cycle strobe; num holds a token.
REQ-006 num  input  WIDTH  unsigned operand token from the interpreter.
REQ-007 op_ready  input  1  one-cycle strobe; op holds a token.
REQ-008 op  input  4  operator code per the shared package.
REQ-009 result_valid  output  1  one-cycle pulse; result/err_code valid.
REQ-010 result  output  WIDTH  evaluated expression value.
REQ-011 err_code  output  3  error of the completed line; 0 = none.
REQ-012 busy  output  1  high while not in IDLE.
REQ-013 depth  output  $clog2(DEPTH)+1  current stack occupancy.

Function
REQ-014 FSM states: IDLE, EXEC, DIV, EMIT, DRAIN; reset state IDLE.
REQ-015 IDLE, num_ready: push num on that edge; depth increments next cycle; push with depth==DEPTH -> ERR_OVERFLOW, DRAIN.
REQ-016 IDLE, op_ready, arithmetic op: depth<2 -> ERR_UNDERFLOW, DRAIN; else latch a=second, b=top, pop both, go EXEC (ADD/SUB/MUL) or DIV (DIV).
REQ-017 EXEC lasts one cycle: push a+b, a-b, or a*b low WIDTH bits, all modulo 2^WIDTH unsigned; return IDLE; op-to-depth-update latency 2 cycles.
REQ-018 DIV: b==0 -> ERR_DIVZERO, DRAIN; else floor(a/b) pushed after WIDTH+1 cycles in DIV, then IDLE.
REQ-019 IDLE, op==OP_EOL: depth==1 -> result=top, err_code=0; depth!=1 -> result=0, err_code=ERR_SYNTAX; go EMIT.
REQ-020 EMIT lasts one cycle: result_valid=1, stack cleared (depth=0), return IDLE.
REQ-021 DRAIN: discard all tokens except OP_EOL; OP_EOL -> result=0, err_code=first latched error, EMIT.
REQ-022 Token strobe while busy and not DRAIN: dropped, ERR_OVERRUN latched, go DRAIN after the current operation completes.
REQ-023 num_ready and op_ready in same cycle: num processed, op dropped, ERR_OVERRUN, DRAIN.
REQ-024 Unknown op code -> ERR_SYNTAX, DRAIN.
REQ-025 Only the first error of a line is reported; later errors ignored until EMIT.
REQ-026 result and err_code hold their values until the next EMIT.

Reset
REQ-027 rst_n low: state IDLE, depth 0, result 0, err_code 0, result_valid 0, busy 0, latched error cleared, immediately and asynchronously.
REQ-028 Reset asserted mid-DIV or mid-DRAIN aborts the operation; no result_valid is produced for that line.

Configuration
REQ-029 Macro RPN_DIV_EN defined: OP_DIV executes per REQ-018.
REQ-030 RPN_DIV_EN undefined: no divider instantiated; OP_DIV -> ERR_UNSUPPORTED, DRAIN; other ops unchanged.

Structure
REQ-031 Package rpn_pkg holds op codes (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_EOL=15) and error codes (ERR_NONE=0, OVERFLOW=1, UNDERFLOW=2, DIVZERO=3, OVERRUN=4, SYNTAX=5, UNSUPPORTED=6), shared with the interpreter.
REQ-032 One sub-module rpn_divider: restoring, 1 bit per cycle, start/done handshake, WIDTH-bit quotient; compiled only under RPN_DIV_EN.
REQ-033 Stack is a register array with a depth pointer; no RAM macro.

Verification
REQ-034 Tokens 1,12,ADD,2,MUL,EOL -> one result_valid pulse, result=26, err_code=0, depth=0 afterwards.
REQ-035 Tokens 3,5,SUB,EOL -> result=65534 (wrap), err_code=0.
REQ-036 Tokens 7,ADD,9,EOL -> result=0, err_code=2; token 9 discarded.
REQ-037 With RPN_DIV_EN: 100,7,DIV,EOL -> result=14 after DIV lasting WIDTH+1 cycles; 5,0,DIV,EOL -> err_code=3. Without: 100,7,DIV,EOL -> err_code=6.
REQ-038 Push DEPTH+1 numbers then EOL -> err_code=1; num_ready during EXEC -> err_code=4.
REQ-039 rst_n pulsed low mid-DIV -> all outputs zero, no result_valid; next line 2,2,MUL,EOL -> result=4.

Source files
------------

// File: rtl/rpn_pkg.sv
// rpn_pkg: items shared between the RPN evaluator and the token interpreter.
//   - operator codes (4 bit) and error codes (3 bit)
//   - evaluator FSM state type
//   - first_err(): keeps the first error of a line and ignores later ones
package rpn_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_EOL = 4'd15;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_OVERFLOW    = 3'd1;
  localparam logic [2:0] ERR_UNDERFLOW   = 3'd2;
  localparam logic [2:0] ERR_DIVZERO     = 3'd3;
  localparam logic [2:0] ERR_OVERRUN     = 3'd4;
  localparam logic [2:0] ERR_SYNTAX      = 3'd5;
  localparam logic [2:0] ERR_UNSUPPORTED = 3'd6;

  typedef enum logic [2:0] {IDLE, EXEC, DIV, EMIT, DRAIN} state_e;

  function automatic logic [2:0] first_err(input logic [2:0] cur, input logic [2:0] nw);
    return (cur == ERR_NONE) ? nw : cur;
  endfunction

endpackage

// File: rtl/rpn_divider.sv
// rpn_divider: restoring unsigned divider, one quotient bit per cycle.
// Only compiled when RPN_DIV_EN is defined.
//   clk, rst_n   : clock, async active-low reset
//   start_i      : load operands and begin (one cycle)
//   dividend_i   : WIDTH-bit dividend
//   divisor_i    : WIDTH-bit divisor (zero is screened by the caller)
//   done_o       : high for the one cycle quotient_o is final
//   quotient_o   : WIDTH-bit quotient
// Timing: start sampled on edge 0, WIDTH iterations on edges 1..WIDTH,
// done_o high during the following cycle.
`ifdef RPN_DIV_EN
import rpn_pkg::*;

module rpn_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic [WIDTH:0]   shifted, diff;

  // Partial remainder shifted left with the next dividend bit; a set MSB in
  // the trial difference means the divisor did not fit (restore).
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= CW'(WIDTH);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        if (!diff[WIDTH]) begin
          rem_q <= diff[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= shifted[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CW'(1);
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign done_o     = run_q && (cnt_q == '0);
  assign quotient_o = quo_q;

endmodule
`endif

// File: rtl/rpn_stack_evaluator.sv
// rpn_stack_evaluator: evaluates a stream of RPN tokens on a register stack.
// Optional feature macro: RPN_DIV_EN (enables OP_DIV through rpn_divider;
// without it OP_DIV reports ERR_UNSUPPORTED).
//   clk, rst_n        : clock, async active-low reset
//   num_ready, num    : operand token strobe / value
//   op_ready, op      : operator token strobe / code (rpn_pkg)
//   result_valid      : one-cycle pulse while in EMIT
//   result, err_code  : outcome of the last completed line, held until next EMIT
//   busy              : FSM not in IDLE
//   depth             : stack occupancy
import rpn_pkg::*;

module rpn_stack_evaluator #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   num_ready,
  input  logic [WIDTH-1:0]       num,
  input  logic                   op_ready,
  input  logic [3:0]             op,
  output logic                   result_valid,
  output logic [WIDTH-1:0]       result,
  output logic [2:0]             err_code,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] depth
);

  localparam int         PW   = $clog2(DEPTH);
  localparam logic [PW:0] ONE  = (PW+1)'(1);
  localparam logic [PW:0] TWO  = (PW+1)'(2);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [PW:0]      depth_q, depth_d;
  logic [2:0]       err_q, err_d;      // first error of the current line
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       ec_q, ec_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       opc_q, opc_d;

  logic [WIDTH-1:0] stk_q [DEPTH];
  logic             push_en;
  logic [PW-1:0]    push_idx;
  logic [WIDTH-1:0] push_val;
  logic [WIDTH-1:0] top_val, sec_val, alu;
  logic             tok;

  assign top_val = stk_q[PW'(depth_q - ONE)];
  assign sec_val = stk_q[PW'(depth_q - TWO)];
  assign tok     = num_ready | op_ready;

  always_comb begin
    alu = a_q + b_q;
    case (opc_q)
      OP_SUB:  alu = a_q - b_q;
      OP_MUL:  alu = a_q * b_q;
      default: alu = a_q + b_q;
    endcase
  end

`ifdef RPN_DIV_EN
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;

  rpn_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (sec_val),
    .divisor_i  (top_val),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );
`endif

  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    err_d    = err_q;
    res_d    = res_q;
    ec_d     = ec_q;
    a_d      = a_q;
    b_d      = b_q;
    opc_d    = opc_q;
    push_en  = 1'b0;
    push_idx = depth_q[PW-1:0];
    push_val = num;
`ifdef RPN_DIV_EN
    div_start = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (num_ready) begin
          if (depth_q == FULL) begin
            err_d   = first_err(err_d, ERR_OVERFLOW);
            state_d = DRAIN;
          end else begin
            push_en = 1'b1;
            depth_d = depth_q + ONE;
          end
          // The number wins a same-cycle collision; the operator is lost.
          if (op_ready) begin
            err_d   = first_err(err_d, ERR_OVERRUN);
            state_d = DRAIN;
          end
        end else if (op_ready) begin
          case (op)
            OP_EOL: begin
              state_d = EMIT;
              if (depth_q == ONE) begin
                res_d = top_val;
                ec_d  = ERR_NONE;
              end else begin
                res_d = '0;
                ec_d  = ERR_SYNTAX;
              end
            end
            OP_ADD, OP_SUB, OP_MUL: begin
              if (depth_q < TWO) begin
                err_d   = first_err(err_d, ERR_UNDERFLOW);
                state_d = DRAIN;
              end else begin
                a_d     = sec_val;
                b_d     = top_val;
                opc_d   = op;
                depth_d = depth_q - TWO;
                state_d = EXEC;
              end
            end
`ifdef RPN_DIV_EN
            OP_DIV: begin
              if (depth_q < TWO) begin
                err_d   = first_err(err_d, ERR_UNDERFLOW);
                state_d = DRAIN;
              end else begin
                a_d       = sec_val;
                b_d       = top_val;
                opc_d     = op;
                depth_d   = depth_q - TWO;
                div_start = 1'b1;
                state_d   = DIV;
              end
            end
`else
            OP_DIV: begin
              err_d   = first_err(err_d, ERR_UNSUPPORTED);
              state_d = DRAIN;
            end
`endif
            default: begin
              err_d   = first_err(err_d, ERR_SYNTAX);
              state_d = DRAIN;
            end
          endcase
        end
      end

      EXEC: begin
        if (tok) err_d = first_err(err_d, ERR_OVERRUN);
        push_en  = 1'b1;
        push_val = alu;
        depth_d  = depth_q + ONE;
        // A token dropped during the operation diverts to DRAIN once done.
        state_d  = (err_d == ERR_NONE) ? IDLE : DRAIN;
      end

      DIV: begin
`ifdef RPN_DIV_EN
        if (tok) err_d = first_err(err_d, ERR_OVERRUN);
        if (b_q == '0) begin
          err_d   = first_err(err_d, ERR_DIVZERO);
          state_d = DRAIN;
        end else if (div_done) begin
          push_en  = 1'b1;
          push_val = div_quo;
          depth_d  = depth_q + ONE;
          state_d  = (err_d == ERR_NONE) ? IDLE : DRAIN;
        end
`else
        state_d = IDLE;
`endif
      end

      EMIT: begin
        depth_d = '0;
        err_d   = ERR_NONE;
        if (tok) begin
          err_d   = ERR_OVERRUN;
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end

      DRAIN: begin
        if (op_ready && op == OP_EOL) begin
          res_d   = '0;
          ec_d    = err_q;
          state_d = EMIT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      depth_q <= '0;
      err_q   <= ERR_NONE;
      res_q   <= '0;
      ec_q    <= ERR_NONE;
      a_q     <= '0;
      b_q     <= '0;
      opc_q   <= OP_ADD;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      res_q   <= res_d;
      ec_q    <= ec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opc_q   <= opc_d;
    end
  end

  // Stack contents need no reset: depth_q gates every read.
  always_ff @(posedge clk) begin
    if (push_en) stk_q[push_idx] <= push_val;
  end

  assign result_valid = (state_q == EMIT);
  assign busy         = (state_q != IDLE);
  assign result       = res_q;
  assign err_code     = ec_q;
  assign depth        = depth_q;

endmodule

// File: tb/tb_rpn_stack_evaluator.sv
// Bench for rpn_stack_evaluator: directed lines plus random lines checked
// against a queue-based RPN model. Honours RPN_DIV_EN like the design.
module tb_rpn_stack_evaluator;
  import rpn_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             num_ready = 1'b0;
  logic [WIDTH-1:0] num = '0;
  logic             op_ready = 1'b0;
  logic [3:0]       op = '0;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic [2:0]       err_code;
  logic             busy;
  logic [DW-1:0]    depth;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit               is_num;
    logic [WIDTH-1:0] val;
    logic [3:0]       op;
  } tok_t;

  tok_t             line[$];
  logic [WIDTH-1:0] m_stk[$];
  logic [2:0]       m_err;

  always #5 clk = ~clk;

  rpn_stack_evaluator #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .num_ready    (num_ready),
    .num          (num),
    .op_ready     (op_ready),
    .op           (op),
    .result_valid (result_valid),
    .result       (result),
    .err_code     (err_code),
    .busy         (busy),
    .depth        (depth)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic tok_t mk_num(input logic [WIDTH-1:0] v);
    tok_t t;
    t.is_num = 1'b1; t.val = v; t.op = '0;
    return t;
  endfunction

  function automatic tok_t mk_op(input logic [3:0] o);
    tok_t t;
    t.is_num = 1'b0; t.val = '0; t.op = o;
    return t;
  endfunction

  function automatic void pn(input logic [WIDTH-1:0] v);
    line.push_back(mk_num(v));
  endfunction

  function automatic void po(input logic [3:0] o);
    line.push_back(mk_op(o));
  endfunction

  // Called at a negedge; strobe lasts one full cycle.
  task automatic send_tok(input tok_t t);
    if (t.is_num) begin num_ready = 1'b1; num = t.val; end
    else begin op_ready = 1'b1; op = t.op; end
    @(negedge clk);
    num_ready = 1'b0;
    op_ready  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " idle"}, busy, 0);
  endtask

  // Reference semantics: plain stack arithmetic on a queue.
  function automatic void model_step(input tok_t t);
    logic [31:0] a, b;
    if (m_err != ERR_NONE) return;
    if (t.is_num) begin
      if (m_stk.size() == DEPTH) m_err = ERR_OVERFLOW;
      else m_stk.push_back(t.val);
      return;
    end
    if (!(t.op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV})) begin
      m_err = ERR_SYNTAX;
      return;
    end
`ifndef RPN_DIV_EN
    if (t.op == OP_DIV) begin
      m_err = ERR_UNSUPPORTED;
      return;
    end
`endif
    if (m_stk.size() < 2) begin
      m_err = ERR_UNDERFLOW;
      return;
    end
    b = 32'(m_stk.pop_back());
    a = 32'(m_stk.pop_back());
    case (t.op)
      OP_ADD:  m_stk.push_back(WIDTH'(a + b));
      OP_SUB:  m_stk.push_back(WIDTH'(a - b));
      OP_MUL:  m_stk.push_back(WIDTH'(a * b));
      default: begin
        if (b == 0) m_err = ERR_DIVZERO;
        else m_stk.push_back(WIDTH'(a / b));
      end
    endcase
  endfunction

  task automatic finish_line(input logic [WIDTH-1:0] exp_res, input logic [2:0] exp_err,
                             input string tag);
    send_tok(mk_op(OP_EOL));
    chk({tag, " rv"}, result_valid, 1);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " err"}, err_code, exp_err);
    @(negedge clk);
    chk({tag, " rv end"}, result_valid, 0);
    chk({tag, " depth end"}, depth, 0);
    chk({tag, " busy end"}, busy, 0);
    chk({tag, " hold"}, result, exp_res);
  endtask

  task automatic run_line(input string tag);
    logic [WIDTH-1:0] er;
    logic [2:0]       ee;
    m_stk.delete();
    m_err = ERR_NONE;
    foreach (line[i]) begin
      send_tok(line[i]);
      model_step(line[i]);
      if (m_err == ERR_NONE) begin
        wait_idle(tag);
        chk({tag, " depth"}, depth, m_stk.size());
      end else begin
        repeat (2) @(negedge clk);
      end
    end
    if (m_err != ERR_NONE) begin er = '0; ee = m_err; end
    else if (m_stk.size() == 1) begin er = m_stk[0]; ee = ERR_NONE; end
    else begin er = '0; ee = ERR_SYNTAX; end
    finish_line(er, ee, tag);
    line.delete();
  endtask

  initial begin
    int n;
    int len;
    int r;

    repeat (3) @(negedge clk);
    chk("reset rv", result_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset depth", depth, 0);
    chk("reset result", result, 0);
    chk("reset err", err_code, 0);
    rst_n = 1'b1;
    @(negedge clk);

    pn(1); pn(12); po(OP_ADD); pn(2); po(OP_MUL);
    run_line("expr26");
    chk("expr26 value", result, 26);
    chk("expr26 code", err_code, 0);

    // Reset in the middle of a long operation aborts the line silently.
`ifdef RPN_DIV_EN
    send_tok(mk_num(16'd100)); wait_idle("rdiv");
    send_tok(mk_num(16'd7));   wait_idle("rdiv");
    send_tok(mk_op(OP_DIV));
    repeat (4) @(negedge clk);
`else
    send_tok(mk_num(16'd7)); wait_idle("rdrn");
    send_tok(mk_op(OP_ADD));
    repeat (2) @(negedge clk);
`endif
    chk("pre reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid reset result", result, 0);
    chk("mid reset err", err_code, 0);
    chk("mid reset rv", result_valid, 0);
    chk("mid reset busy", busy, 0);
    chk("mid reset depth", depth, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post reset rv", result_valid, 0);
    end
    pn(2); pn(2); po(OP_MUL);
    run_line("post reset");
    chk("post reset value", result, 4);

    pn(3); pn(5); po(OP_SUB);
    run_line("wrap");
    chk("wrap value", result, 65534);
    chk("wrap code", err_code, 0);

    pn(7); po(OP_ADD); pn(9);
    run_line("underflow");
    chk("underflow code", err_code, ERR_UNDERFLOW);

`ifdef RPN_DIV_EN
    send_tok(mk_num(16'd100)); wait_idle("div");
    send_tok(mk_num(16'd7));   wait_idle("div");
    send_tok(mk_op(OP_DIV));
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("div cycles", n, WIDTH + 1);
    chk("div depth", depth, 1);
    finish_line(16'd14, ERR_NONE, "div");

    pn(5); pn(0); po(OP_DIV);
    run_line("divzero");
    chk("divzero code", err_code, ERR_DIVZERO);
`else
    pn(100); pn(7); po(OP_DIV);
    run_line("nodiv");
    chk("nodiv code", err_code, ERR_UNSUPPORTED);
`endif

    for (int k = 0; k < DEPTH + 1; k++) pn(WIDTH'(k + 1));
    run_line("overflow");
    chk("overflow code", err_code, ERR_OVERFLOW);

    // Number strobed while the adder result is being written back.
    send_tok(mk_num(16'd2)); wait_idle("ovr");
    send_tok(mk_num(16'd3)); wait_idle("ovr");
    send_tok(mk_op(OP_ADD));
    send_tok(mk_num(16'd9));
    finish_line('0, ERR_OVERRUN, "overrun exec");

    num_ready = 1'b1; num = 16'd5; op_ready = 1'b1; op = OP_ADD;
    @(negedge clk);
    num_ready = 1'b0; op_ready = 1'b0;
    finish_line('0, ERR_OVERRUN, "collision");

    pn(4); po(4'd9);
    run_line("badop");
    chk("badop code", err_code, ERR_SYNTAX);

    run_line("empty");

    for (int l = 0; l < 40; l++) begin
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 99);
        if (r < 58) pn(($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(0, 20)) : WIDTH'($urandom));
        else if (r < 70) po(OP_ADD);
        else if (r < 80) po(OP_SUB);
        else if (r < 90) po(OP_MUL);
        else if (r < 97) po(OP_DIV);
        else po(4'd9);
      end
      run_line("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
